// File: rtl/sqrt_rr_if.sv
// Bundle between the square-root scheduler, its client masters and the shared core.
// The master modport is the client/core side; the slave modport is the scheduler.
interface sqrt_rr_if #(
    parameter int N_REQ = 4
);
    localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    // Client request side
    logic [N_REQ-1:0]    req_valid;
    logic [32*N_REQ-1:0] req_radicand;
    logic [N_REQ-1:0]    req_ready;

    // Client response side
    logic [N_REQ-1:0]    resp_valid;
    logic [15:0]         resp_root;
    logic                resp_err;
    logic [IDW-1:0]      resp_id;

    // Shared core port
    logic                core_start;
    logic [31:0]         core_radicand;
    logic [31:0]         core_root;
    logic                core_busy;
    logic                core_done;

    // Statistics
    logic [15:0]         ops_count;

    modport master (
        output req_valid, req_radicand, core_root, core_busy, core_done,
        input  req_ready, resp_valid, resp_root, resp_err, resp_id,
               core_start, core_radicand, ops_count
    );

    modport slave (
        input  req_valid, req_radicand, core_root, core_busy, core_done,
        output req_ready, resp_valid, resp_root, resp_err, resp_id,
               core_start, core_radicand, ops_count
    );
endinterface

// File: rtl/sqrt_rr_scheduler.sv
// Round-robin scheduler sharing one iterative 32-bit square-root core among
// N_REQ requesters. One operation in flight; a watchdog aborts a WAIT that
// never sees core_done and returns an error response with root 0.
module sqrt_rr_scheduler #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 32
) (
    input  logic        clk,
    input  logic        rst,
    sqrt_rr_if.slave    bus
);
    localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW  = $clog2(TIMEOUT);
    localparam logic [CW-1:0]  WAIT_LAST  = CW'(TIMEOUT - 1);
    localparam logic [IDW-1:0] GRANT_INIT = IDW'(N_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic [IDW-1:0]  last_grant;
    logic [IDW-1:0]  id_q;
    logic [31:0]     rad_q;
    logic [CW-1:0]   wait_cnt;
    logic [15:0]     resp_root_q;
    logic            resp_err_q;
    logic [IDW-1:0]  resp_id_q;
    logic [15:0]     ops_q;

    logic            pick_found;
    logic [IDW-1:0]  pick_id;
    logic            start_ok;
    logic            wait_end;

    logic [N_REQ-1:0] ready_c;
    logic [N_REQ-1:0] resp_valid_c;
    logic             start_c;

    // The root of a 32-bit radicand fits in 16 bits; the core's upper bits are always zero.
    logic unused_root_hi;
    assign unused_root_hi = ^bus.core_root[31:16];

    // Round-robin search: first valid requester after the last one served.
    always_comb begin
        logic [IDW-1:0] cand;
        // NOTE: every variable written here gets a default first, so no latch is inferred.
        pick_found = 1'b0;
        pick_id    = last_grant;
        cand       = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = IDW'((int'(last_grant) + k) % N_REQ);
            if (!pick_found && bus.req_valid[cand]) begin
                pick_found = 1'b1;
                pick_id    = cand;
            end
        end
    end

    assign start_ok = pick_found && !bus.core_busy && !bus.core_done;
    assign wait_end = bus.core_done || (wait_cnt == WAIT_LAST);

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so every flop sees pre-edge values.
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and the one-cycle handshake pulses.
    always_comb begin
        state_nxt    = state;
        ready_c      = '0;
        resp_valid_c = '0;
        start_c      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_ok) begin
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                ready_c[id_q] = 1'b1;
                start_c       = 1'b1;
                state_nxt     = S_WAIT;
            end
            S_WAIT: begin
                if (wait_end) begin
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                resp_valid_c[id_q] = 1'b1;
                state_nxt          = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Operation datapath: latch request, run watchdog, capture result, bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant  <= GRANT_INIT;
            id_q        <= '0;
            rad_q       <= '0;
            wait_cnt    <= '0;
            resp_root_q <= '0;
            resp_err_q  <= 1'b0;
            resp_id_q   <= '0;
            ops_q       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_ok) begin
                        id_q  <= pick_id;
                        rad_q <= bus.req_radicand[32*int'(pick_id) +: 32];
                    end
                end
                S_ISSUE: begin
                    wait_cnt <= '0;
                end
                S_WAIT: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    // A done arriving on the watchdog's last cycle still returns a good result.
                    if (bus.core_done) begin
                        resp_root_q <= bus.core_root[15:0];
                        resp_err_q  <= 1'b0;
                        resp_id_q   <= id_q;
                    end else if (wait_cnt == WAIT_LAST) begin
                        resp_root_q <= '0;
                        resp_err_q  <= 1'b1;
                        resp_id_q   <= id_q;
                    end
                end
                S_RESP: begin
                    last_grant <= id_q;
                    ops_q      <= ops_q + 16'd1;
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready     = ready_c;
    assign bus.core_start    = start_c;
    assign bus.core_radicand = rad_q;
    assign bus.resp_valid    = resp_valid_c;
    assign bus.resp_root     = resp_root_q;
    assign bus.resp_err      = resp_err_q;
    assign bus.resp_id       = resp_id_q;
    assign bus.ops_count     = ops_q;
endmodule
